// File: rtl/wash_event_gen.sv
// Event generator feeding the washer control FSM: start debounce, fill detection, phase timing, fault.
// Optional build macro WASH_PAUSE_EN adds a pause input that freezes counters and event outputs.

module wash_event_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FULL_LEVEL      = 200,
  parameter int unsigned SHAKE_CYCLES    = 1000,
  parameter int unsigned TURN_CYCLES     = 500,
  parameter int unsigned FILL_TIMEOUT    = 4000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic [7:0] level,
  input  logic       level_valid,
  input  logic       valve,
  input  logic       shake_mode,
  input  logic       turn_mode,
`ifdef WASH_PAUSE_EN
  input  logic       pause,
`endif
  output logic       start,
  output logic       full,
  output logic       Time,
  output logic       dry,
  output logic       fault
);

  localparam int unsigned     DebW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DebW-1:0] DebMax    = DebW'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] ShakeLast = CNT_W'(SHAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TurnLast  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FillLimit = CNT_W'(FILL_TIMEOUT);

  typedef enum logic [2:0] {StIdle, StFill, StShake, StTurn, StFault} phase_e;

  phase_e            phase_q, phase_d;
  logic              sync1_q, sync2_q;
  logic [DebW-1:0]   deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              hit_q, hit_d;
  logic              start_q, start_d;
  logic              full_q, full_d;
  logic              time_q, time_d;
  logic              dry_q, dry_d;
  logic              fault_q;
  logic              multi, level_ok, stay, hold;
  logic              paused;

`ifdef WASH_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  always_comb begin
    multi    = (valve & shake_mode) | (valve & turn_mode) | (shake_mode & turn_mode);
    cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    level_ok = ({24'd0, level} >= FULL_LEVEL);

    phase_d = StIdle;
    if (phase_q == StFault || multi) phase_d = StFault;
    else if (valve)                  phase_d = StFill;
    else if (shake_mode)             phase_d = StShake;
    else if (turn_mode)              phase_d = StTurn;

    // Timeout is judged on the count this edge would produce.
    if (phase_q == StFill && phase_d == StFill && !paused && !full_q && cnt_inc == FillLimit) begin
      phase_d = StFault;
    end

    stay = (phase_d == phase_q);
    hold = stay & paused;

    cnt_d = '0;
    if (stay) begin
      if (paused || phase_q == StIdle || phase_q == StFault) cnt_d = cnt_q;
      else                                                   cnt_d = cnt_inc;
    end

    // hit_q remembers that the previous valid sample was already at or above the threshold.
    hit_d  = 1'b0;
    full_d = 1'b0;
    if (phase_d == StFill) begin
      hit_d  = hit_q;
      full_d = full_q;
      if (!hold && level_valid) begin
        hit_d  = level_ok;
        full_d = full_q | (hit_q & level_ok);
      end
    end

    time_d = 1'b0;
    if (stay && phase_q == StShake) begin
      time_d = hold ? time_q : (time_q | (cnt_d == ShakeLast));
    end

    dry_d = 1'b0;
    if (stay && phase_q == StTurn) begin
      dry_d = hold ? dry_q : (dry_q | (cnt_d == TurnLast));
    end

    // Counter parks at DebMax until the button is released, so one press gives one pulse.
    if (!sync2_q)                        deb_d = '0;
    else if (paused || deb_q == DebMax)  deb_d = deb_q;
    else                                 deb_d = deb_q + 1'b1;

    start_d = sync2_q & ~paused & (deb_q == DebMax - 1'b1) & ~valve & ~shake_mode & ~turn_mode &
              (phase_q != StFault);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= StIdle;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      start_q <= 1'b0;
      full_q  <= 1'b0;
      time_q  <= 1'b0;
      dry_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sync1_q <= start_btn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      start_q <= start_d;
      full_q  <= full_d;
      time_q  <= time_d;
      dry_q   <= dry_d;
      fault_q <= (phase_d == StFault);
    end
  end

  assign start = start_q;
  assign full  = full_q;
  assign Time  = time_q;
  assign dry   = dry_q;
  assign fault = fault_q;

endmodule
